// File: rtl/compressor.sv
// 3-bit coefficient compressor: streams 512 coefficients from poly RAM and
// packs their rounded 3-bit values into 192 consecutive bytes of byte RAM.
module compressor #(
    parameter logic [10:0] BYTE_BASE = 11'd896
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        done,
    output logic [8:0]  poly_addr,
    input  logic [15:0] poly_do,
    output logic        byte_wea,
    output logic [10:0] byte_addr,
    output logic [7:0]  byte_dia
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    localparam logic [13:0] THR [8] = '{14'd769, 14'd2305, 14'd3841, 14'd5377,
                                        14'd6913, 14'd8449, 14'd9985, 14'd11521};

    state_t      state;
    logic [9:0]  cyc;
    logic [23:0] acc;
    logic [23:0] obuf;
    logic [10:0] wptr;
    logic [13:0] x;
    logic [13:0] xf;
    logic [3:0]  cnt;
    logic [2:0]  t;

    // Rounding by threshold count; a count of 8 wraps to 0.
    always_comb begin
        x   = poly_do[13:0];
        xf  = (x >= 14'd12289) ? x - 14'd12289 : x;
        cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            if (xf >= THR[i]) begin
                cnt = cnt + 4'd1;
            end
        end
        t = cnt[2:0];
    end

    // cyc is the relative cycle number of the run; acc fills little-endian so a
    // full group is exactly the three output bytes, which obuf holds while the
    // next group starts filling acc.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cyc       <= 10'd0;
            acc       <= 24'd0;
            obuf      <= 24'd0;
            wptr      <= BYTE_BASE;
            done      <= 1'b0;
            byte_wea  <= 1'b0;
            poly_addr <= 9'd0;
            byte_addr <= BYTE_BASE;
            byte_dia  <= 8'd0;
        end else begin
            done     <= 1'b0;
            byte_wea <= 1'b0;
            case (state)
                IDLE: begin
                    poly_addr <= 9'd0;
                    if (start) begin
                        state <= READ;
                        cyc   <= 10'd0;
                        wptr  <= BYTE_BASE;
                        acc   <= 24'd0;
                    end
                end
                READ, DRAIN: begin
                    cyc <= cyc + 10'd1;
                    if (state == READ) begin
                        if (cyc == 10'd511) begin
                            state     <= DRAIN;
                            poly_addr <= 9'd0;
                        end else begin
                            poly_addr <= cyc[8:0] + 9'd1;
                        end
                    end
                    if (cyc >= 10'd1 && cyc <= 10'd512) begin
                        acc <= {t, acc[23:3]};
                    end
                    if (cyc >= 10'd9) begin
                        case (cyc[2:0])
                            3'd1: begin
                                obuf      <= acc;
                                byte_wea  <= 1'b1;
                                byte_addr <= wptr;
                                byte_dia  <= acc[7:0];
                                wptr      <= wptr + 11'd1;
                            end
                            3'd2: begin
                                byte_wea  <= 1'b1;
                                byte_addr <= wptr;
                                byte_dia  <= obuf[15:8];
                                wptr      <= wptr + 11'd1;
                            end
                            3'd3: begin
                                byte_wea  <= 1'b1;
                                byte_addr <= wptr;
                                byte_dia  <= obuf[23:16];
                                wptr      <= wptr + 11'd1;
                            end
                            default: ;
                        endcase
                    end
                    if (state == DRAIN && cyc == 10'd516) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
